// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - control FSM for a shift-add signed multiplier (X:A:B register file)
// Optional feature macro: MULT_SEQ_SKIP_ZERO_EN (shift directly on zero multiplier bits)
module mult_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_Ld,
    output logic Clr_XA,
    output logic Add,
    output logic Sub,
    output logic Shift,
    output logic Busy,
    output logic Done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_DONE    = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;

    logic start;
    logic last;

    // Run edge detect; run_q resets high so a Run held through reset never starts a multiply
    assign run_d = Run;
    assign start = Run & ~run_q;
    assign last  = (cnt_q == LAST_CNT);

    // State, bit counter and Run history registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            run_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

    // Next-state and counter update; the counter stops at the last bit instead of wrapping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                state_d = ST_COMPUTE;
            end
            ST_COMPUTE: begin
`ifdef MULT_SEQ_SKIP_ZERO_EN
                if (M) begin
                    state_d = ST_SHIFT;
                end else if (last) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = ST_COMPUTE;
                end
`else
                state_d = ST_SHIFT;
`endif
            end
            ST_SHIFT: begin
                if (last) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = ST_COMPUTE;
                end
            end
            ST_DONE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!Run) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: Moore on state, Add/Sub also qualified by M and the last-bit flag
    always_comb begin
        Clr_Ld = 1'b0;
        Clr_XA = 1'b0;
        Add    = 1'b0;
        Sub    = 1'b0;
        Shift  = 1'b0;
        Busy   = 1'b0;
        Done   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Level-following load request; a start in the same cycle suppresses it,
                // and reset forces it low since ClearA_LoadB is not itself reset
                Clr_Ld = ClearA_LoadB & ~start & Reset_n;
            end
            ST_CLEAR: begin
                Clr_XA = 1'b1;
                Busy   = 1'b1;
            end
            ST_COMPUTE: begin
                Busy = 1'b1;
                Add  = M & ~last;
                Sub  = M & last;
`ifdef MULT_SEQ_SKIP_ZERO_EN
                Shift = ~M;
`endif
            end
            ST_SHIFT: begin
                Shift = 1'b1;
                Busy  = 1'b1;
            end
            ST_DONE: begin
                Done = 1'b1;
            end
            default: begin
                Clr_Ld = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - scoreboard bench for mult_sequencer with X:A:B register file model
module tb_mult_sequencer;

    localparam int W = 8;

    logic Clk = 1'b0;
    logic Reset_n;
    logic Run;
    logic ClearA_LoadB;
    logic M;
    logic Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done;

    mult_sequencer #(.WIDTH(W)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .M            (M),
        .Clr_Ld       (Clr_Ld),
        .Clr_XA       (Clr_XA),
        .Add          (Add),
        .Sub          (Sub),
        .Shift        (Shift),
        .Busy         (Busy),
        .Done         (Done)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Register file driven by the sequencer's enables
    logic         x_r = 1'b0;
    logic [W-1:0] a_r = '0;
    logic [W-1:0] b_r = '0;
    logic [W-1:0] s_val = '0;
    logic [W-1:0] sw_val = '0;

    always @(posedge Clk) begin
        if (Clr_Ld) begin
            x_r <= 1'b0;
            a_r <= '0;
            b_r <= sw_val;
        end else if (Clr_XA) begin
            x_r <= 1'b0;
            a_r <= '0;
        end else if (Add) begin
            {x_r, a_r} <= {a_r[W-1], a_r} + {s_val[W-1], s_val};
        end else if (Sub) begin
            {x_r, a_r} <= {a_r[W-1], a_r} - {s_val[W-1], s_val};
        end else if (Shift) begin
            a_r <= {x_r, a_r[W-1:1]};
            b_r <= {a_r[0], b_r[W-1:1]};
        end
    end

    assign M = b_r[0];

    typedef struct {
        int         t;
        logic [5:0] v;   // {Clr_Ld, Clr_XA, Add, Sub, Shift, Done}
    } ev_t;

    ev_t              exp_q[$];
    logic [2*W-1:0]   prod_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expected event whenever the sequencer drives an action
    always @(negedge Clk) begin
        logic [5:0] vec;
        ev_t        e;
        logic [2*W-1:0] p;
        vec = {Clr_Ld, Clr_XA, Add, Sub, Shift, Done};
        if (Reset_n && (Clr_XA || Add || Sub || Shift || Done)) begin
            check("onehot_actions", longint'($onehot(vec)), 1);
            if (exp_q.size() == 0) begin
                check("unexpected_output", longint'(vec), 0);
            end else begin
                e = exp_q.pop_front();
                check("event_cycle", cyc, e.t);
                check("event_vector", longint'(vec), longint'(e.v));
                check("busy_level", longint'(Busy), longint'(!Done));
                if (Done) begin
                    done_cnt++;
                    if (prod_q.size() == 0) begin
                        check("product_queue_empty", 1, 0);
                    end else begin
                        p = prod_q.pop_front();
                        check("product", longint'({a_r, b_r}), longint'(p));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Expected action sequence, built from the per-bit timing rules
    task automatic push_events(input int t0, input logic [W-1:0] b);
        ev_t e;
        int  t;
        e.t = t0 + 1; e.v = 6'b010000; exp_q.push_back(e);
        t = t0 + 2;
        for (int i = 0; i < W; i++) begin
            if (b[i]) begin
                e.t = t;     e.v = (i == W - 1) ? 6'b000100 : 6'b001000; exp_q.push_back(e);
                e.t = t + 1; e.v = 6'b000010; exp_q.push_back(e);
                t = t + 2;
            end else begin
`ifdef MULT_SEQ_SKIP_ZERO_EN
                e.t = t;     e.v = 6'b000010; exp_q.push_back(e);
                t = t + 1;
`else
                e.t = t + 1; e.v = 6'b000010; exp_q.push_back(e);
                t = t + 2;
`endif
            end
        end
        e.t = t; e.v = 6'b000001; exp_q.push_back(e);
    endtask

    task automatic load_b(input logic [W-1:0] b);
        sw_val = b;
        ClearA_LoadB = 1'b1;
        #1 check("clr_ld_follow_high", longint'(Clr_Ld), 1);
        tick();
        ClearA_LoadB = 1'b0;
        #1 check("clr_ld_follow_low", longint'(Clr_Ld), 0);
    endtask

    task automatic run_mult(input logic [W-1:0] s, input logic [W-1:0] b, input bit hold);
        logic signed [W-1:0]   ss;
        logic signed [W-1:0]   bs;
        logic signed [2*W-1:0] p;
        int start_done;
        bit seen;
        s_val = s;
        load_b(b);
        ss = s;
        bs = b;
        p  = ss * bs;
        prod_q.push_back(p);
        push_events(cyc, b);
        start_done = done_cnt;
        Run = 1'b1;
        tick();
        if (!hold) Run = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge Clk);
            #1;
            if (done_cnt != start_done) seen = 1'b1;
        end
        check("done_within_budget", longint'(seen), 1);
        check("events_consumed", exp_q.size(), 0);
        exp_q.delete();
        prod_q.delete();
        tick();
        if (hold) begin
            ClearA_LoadB = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                check("hold_clr_ld", longint'(Clr_Ld), 0);
                check("hold_busy", longint'(Busy), 0);
            end
            Run = 1'b0;
            #1 check("hold_exit_clr_ld", longint'(Clr_Ld), 0);
            tick();
            check("idle_clr_ld_after_hold", longint'(Clr_Ld), 1);
            ClearA_LoadB = 1'b0;
            tick();
        end else begin
            tick();
            tick();
        end
    endtask

    initial begin
        logic [6:0] outs;
        int         dref;
        Reset_n = 1'b0;
        Run = 1'b1;
        ClearA_LoadB = 1'b1;
        repeat (3) tick();
        outs = {Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done};
        check("outputs_in_reset", longint'(outs), 0);
        ClearA_LoadB = 1'b0;
        Reset_n = 1'b1;
        repeat (4) tick();
        check("no_start_after_reset", longint'(Busy), 0);
        check("no_done_after_reset", done_cnt, 0);
        Run = 1'b0;
        tick();

        run_mult(8'h5B, 8'h07, 1'b0);
        run_mult(8'h25, 8'h80, 1'b1);
        run_mult(8'h80, 8'h80, 1'b0);
        run_mult(8'hC3, 8'hFF, 1'b0);
        run_mult(8'h7F, 8'h00, 1'b1);

        // Reset in the middle of a run
        s_val = 8'h33;
        load_b(8'hA5);
        push_events(cyc, 8'hA5);
        dref = done_cnt;
        Run = 1'b1;
        for (int k = 0; k < 9; k++) tick();
        Reset_n = 1'b0;
        #1;
        outs = {Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done};
        check("outputs_on_abort", longint'(outs), 0);
        exp_q.delete();
        prod_q.delete();
        tick();
        Reset_n = 1'b1;
        repeat (25) tick();
        check("no_done_after_abort", done_cnt, dref);
        check("idle_after_abort", longint'(Busy), 0);
        Run = 1'b0;
        tick();

        for (int r = 0; r < 8; r++) begin
            run_mult(W'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
